// File: rtl/melody_sequencer_if.sv
// Control and status bundle between the player front end and melody_sequencer.
// master drives the play controls; slave is the sequencer side.
interface melody_sequencer_if;
  logic        start;
  logic        stop;
  logic        pause;
  logic        loop_en;
  logic [1:0]  tempo_sel;
  logic [19:0] note_div;
  logic [11:0] note_disp;
  logic [4:0]  step_idx;
  logic        busy;
  logic        done;

  modport master (
    output start, stop, pause, loop_en, tempo_sel,
    input  note_div, note_disp, step_idx, busy, done
  );

  modport slave (
    input  start, stop, pause, loop_en, tempo_sel,
    output note_div, note_disp, step_idx, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Song ROM player: steps IDLE -> LOAD -> PLAY -> GAP and drives the
// buzzer divider, the two display digit codes and busy/done status.
module melody_sequencer #(
  parameter int          TICKS_PER_BEAT = 10_000_000,
  parameter int          GAP_TICKS      = 400_000,
  parameter logic [5:0]  DISP_BLANK     = 6'd63
) (
  input logic               clk,
  input logic               rst,
  melody_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  localparam logic [3:0]  CODE_END = 4'd15;
  localparam logic [31:0] T_X1     = 32'(TICKS_PER_BEAT);
  localparam logic [31:0] T_HALF   = 32'(TICKS_PER_BEAT * 2);
  localparam logic [31:0] T_DBL    = 32'(TICKS_PER_BEAT / 2);
  localparam logic [31:0] GAP_LEN  = 32'(GAP_TICKS);
  localparam logic [11:0] BLANK2   = {DISP_BLANK, DISP_BLANK};

  // {code[3:0], dur[1:0]}; dur encodes beats-1
  function automatic logic [5:0] rom(input logic [4:0] i);
    case (i)
      5'd0:    rom = {4'd1, 2'd0};
      5'd1:    rom = {4'd1, 2'd0};
      5'd2:    rom = {4'd5, 2'd0};
      5'd3:    rom = {4'd5, 2'd0};
      5'd4:    rom = {4'd6, 2'd0};
      5'd5:    rom = {4'd6, 2'd0};
      5'd6:    rom = {4'd5, 2'd1};
      5'd7:    rom = {4'd4, 2'd0};
      5'd8:    rom = {4'd4, 2'd0};
      5'd9:    rom = {4'd3, 2'd0};
      5'd10:   rom = {4'd3, 2'd0};
      5'd11:   rom = {4'd2, 2'd0};
      5'd12:   rom = {4'd2, 2'd0};
      5'd13:   rom = {4'd1, 2'd1};
      default: rom = {CODE_END, 2'd0};
    endcase
  endfunction

  function automatic logic [19:0] oct4_div(input logic [2:0] n);
    case (n)
      3'd1:    oct4_div = 20'd152889;
      3'd2:    oct4_div = 20'd136213;
      3'd3:    oct4_div = 20'd121349;
      3'd4:    oct4_div = 20'd114538;
      3'd5:    oct4_div = 20'd102041;
      3'd6:    oct4_div = 20'd90909;
      3'd7:    oct4_div = 20'd80991;
      default: oct4_div = 20'd0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [19:0] div_q, div_d;
  logic [11:0] disp_q, disp_d;
  logic        done_q, done_d;

  logic [5:0]  entry;
  logic [3:0]  code;
  logic [3:0]  num;
  logic        hi_oct;
  logic [2:0]  beats;
  logic [31:0] t_sel;
  logic [31:0] play_len;
  logic [19:0] code_div;

  always_comb begin
    entry    = rom(idx_q);
    code     = entry[5:2];
    beats    = {1'b0, entry[1:0]} + 3'd1;
    hi_oct   = code >= 4'd8;
    num      = hi_oct ? code - 4'd7 : code;
    code_div = hi_oct ? oct4_div(num[2:0]) >> 1
                      : oct4_div(num[2:0]);
    unique case (1'b1)
      bus.tempo_sel == 2'b01: t_sel = T_HALF;
      bus.tempo_sel == 2'b10: t_sel = T_DBL;
      default:                t_sel = T_X1;
    endcase
    play_len = 32'(beats) * t_sel - GAP_LEN;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    div_d   = div_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      div_d   = '0;
      disp_d  = BLANK2;
    end else if (bus.start) begin
      state_d = LOAD;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          if (code == CODE_END) begin
            if (bus.loop_en) begin
              idx_d = '0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = PLAY;
            cnt_d   = play_len - 32'd1;
            div_d   = code_div;
            disp_d  = (code == 4'd0) ? BLANK2
                    : {hi_oct ? 6'd5 : 6'd4, 2'b00, num};
          end
        end
        PLAY: begin
          if (!bus.pause) begin
            if (cnt_q == '0) begin
              state_d = GAP;
              cnt_d   = GAP_LEN - 32'd1;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        GAP: begin
          if (!bus.pause) begin
            if (cnt_q == '0) begin
              state_d = LOAD;
              cnt_d   = '0;
              idx_d   = idx_q + 5'd1;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      disp_q  <= BLANK2;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
    end
  end

  // pause mutes immediately; the held note returns on release
  assign bus.note_div  = (state_q == PLAY && !bus.pause) ? div_q : '0;
  assign bus.note_disp = (state_q == PLAY && !bus.pause) ? disp_q : BLANK2;
  assign bus.step_idx  = idx_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;

endmodule
